// File: rtl/openhw_mul.sv
// Iterative shift-and-add multiplier for the M-extension: stalls Execute while it
// retires BITSPERCYCLE multiplier bits per clock, then presents the product to Memory.
module openhw_mul #(
  parameter int XLEN         = 32,
  parameter int BITSPERCYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            IntMulE,
  input  logic [1:0]      MulOpE,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            MulBusyE,
  output logic [XLEN-1:0] ProdM
);

  localparam int CNTW = $clog2(XLEN) + 1;
  localparam logic [CNTW-1:0] NFULL = CNTW'(XLEN / BITSPERCYCLE);
  localparam logic [CNTW-1:0] NHALF = CNTW'(XLEN / BITSPERCYCLE / 2);
  localparam logic [XLEN-1:0] LOW32 = XLEN'(64'hFFFF_FFFF);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_e;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic isSigned);
    magnitude = (isSigned && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] applySign(input logic signed [2*XLEN-1:0] p,
                                                  input logic neg);
    applySign = neg ? -p : p;
  endfunction

  mulState_e         state;
  logic [CNTW-1:0]   stepCnt;
  logic [XLEN-1:0]   hi, lo, aReg;
  logic              negPM, w64M;
  logic [1:0]        opM;

  logic              w64, signA, signB, negP, opZero, mulStartE;
  logic signed [XLEN-1:0] srcA, srcB;
  logic [XLEN-1:0]   absA, absB;
  logic [XLEN-1:0]   hiNext, loNext;
  logic [XLEN:0]     stepSum;
  logic [2*XLEN-1:0] prodFull;
  logic [31:0]       wordRes;

  // Execute: operand conditioning (W-type truncation, signedness, magnitudes)
  assign w64       = (XLEN == 64) && W64E && (MulOpE == 2'b00);
  assign signA     = (MulOpE == 2'b01) || (MulOpE == 2'b10);
  assign signB     = (MulOpE == 2'b01);
  assign srcA      = w64 ? (ForwardedSrcAE & LOW32) : ForwardedSrcAE;
  assign srcB      = w64 ? (ForwardedSrcBE & LOW32) : ForwardedSrcBE;
  assign negP      = (signA & srcA[XLEN-1]) ^ (signB & srcB[XLEN-1]);
  assign absA      = magnitude(srcA, signA);
  assign absB      = magnitude(srcB, signB);
  assign opZero    = (srcA == '0) || (srcB == '0);
  assign mulStartE = IntMulE && (state == IDLE) && !StallM;
  assign MulBusyE  = (state == BUSY) || mulStartE;

  // Iteration: BITSPERCYCLE chained add-and-shift steps on {C,Hi,Lo}
  always_comb begin
    hiNext  = hi;
    loNext  = lo;
    stepSum = '0;
    for (int i = 0; i < BITSPERCYCLE; i++) begin
      stepSum = loNext[0] ? ({1'b0, hiNext} + {1'b0, aReg}) : {1'b0, hiNext};
      loNext  = {stepSum[0], loNext[XLEN-1:1]};
      hiNext  = stepSum[XLEN:1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      stepCnt <= '0;
      hi      <= '0;
      lo      <= '0;
      aReg    <= '0;
      negPM   <= 1'b0;
      opM     <= 2'b00;
      w64M    <= 1'b0;
    end else if (FlushE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mulStartE) begin
            negPM   <= negP;
            opM     <= MulOpE;
            w64M    <= w64;
            hi      <= '0;
            aReg    <= absA;
            stepCnt <= CNTW'(1);
            if (opZero) begin
              lo    <= '0;
              state <= DONE;
            end else begin
              lo    <= absB;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          hi      <= hiNext;
          lo      <= loNext;
          stepCnt <= stepCnt + CNTW'(1);
          if (stepCnt == (w64M ? NHALF : NFULL)) state <= DONE;
        end
        DONE: begin
          if (!StallM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory: sign correction and result selection; a short mulw run leaves its
  // 32x32 product in the upper half of Lo
  assign prodFull = applySign({hi, lo}, negPM);
  assign wordRes  = prodFull[XLEN-1 -: 32];

  always_comb begin
    ProdM = prodFull[XLEN-1:0];
    if (w64M) begin
      ProdM       = {XLEN{wordRes[31]}};
      ProdM[31:0] = wordRes;
    end else if (opM != 2'b00) begin
      ProdM = prodFull[2*XLEN-1:XLEN];
    end
  end

endmodule
